ram_burst_reader: RTL and testbench

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_reader_pkg.sv | 4 +
 rtl/ram_rd_skid_fifo.sv | 34 +++
 rtl/ram_burst_reader.sv | 90 +++++++++
 tb/tb_ram_burst_reader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ram_burst_reader_pkg.sv
// ram_burst_reader_pkg: shared types for the RAM burst reader
package ram_burst_reader_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
endpackage

// File: rtl/ram_rd_skid_fifo.sv
// ram_rd_skid_fifo: 2-entry FIFO holding returned RAM words with their last flag
module ram_rd_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [1:0]       count_o
);
  logic [WIDTH-1:0] mem_q [2];
  logic             wp_q, rp_q;
  logic [1:0]       cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= ~wp_q;
      end
      if (pop_i) rp_q <= ~rp_q;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  end
  assign dout_o  = mem_q[rp_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: streams a burst of RAM words (1-cycle read latency) with backpressure
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, rd_addr;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d, cur_rem;
  logic                  inflight_q, last_q, done_q, done_d;
  logic                  issue, pop, room;
  logic [1:0]            cnt;
  ram_rd_skid_fifo #(.WIDTH(DATA_WIDTH + 1)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .din_i   ({ram_rdata, last_q}),
    .pop_i   (pop),
    .dout_o  ({out_data, out_last}),
    .count_o (cnt)
  );
  assign out_valid = cnt != 2'd0;
  assign pop       = out_valid && out_ready;
  // room counts the slot freed by this cycle's pop so a full-rate stream never stalls
  assign room      = (2'(inflight_q) + cnt - 2'(pop)) < 2'd2;
  // the first read issues in the accepting cycle; rst_n gating keeps ram_en low in reset
  assign issue     = rst_n && ((state_q == IDLE) ? (cmd_valid && cmd_len != '0) : (state_q == RUN && room));
  assign rd_addr   = (state_q == IDLE) ? cmd_base : addr_q;
  assign cur_rem   = (state_q == IDLE) ? cmd_len : rem_q;
  assign ram_en    = issue;
  assign ram_addr  = issue ? rd_addr : '0;
  assign ram_we    = 1'b0;
  assign ram_wdata = '0;
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (issue) begin
      addr_d  = rd_addr + ADDR_WIDTH'(1);
      rem_d   = cur_rem - LEN_WIDTH'(1);
      state_d = (cur_rem == LEN_WIDTH'(1)) ? DRAIN : RUN;
    end else if (state_q == IDLE && cmd_valid) begin
      done_d = 1'b1;
    end else if (state_q == DRAIN && pop && out_last) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= issue;
      last_q     <= issue && cur_rem == LEN_WIDTH'(1);
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: table-driven and random bursts checked against a burst-level model
module tb_ram_burst_reader;
  localparam int AW = 10, DW = 32, LW = 11;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, ram_en, ram_we, out_valid, out_ready, out_last, busy, done;
  logic [AW-1:0] cmd_base, ram_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] ram_wdata, ram_rdata, out_data;
  logic [DW-1:0] ram [1<<AW];
  int            n_chk = 0, n_fail = 0;
  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    int            mode;
    int            exp_lat;
    logic [AW-1:0] exp_last;
    int            abort_at;
  } vec_t;
  vec_t vecs[11];
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_en) ram_rdata <= ram[ram_addr];
  ram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic ready_for(input int mode, input int cyc);
    return mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
  endfunction
  task automatic chk_quiet(input string tag);
    chk({tag, "_ram_en"}, 32'(ram_en), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk_quiet("rst");
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_hold_done", 32'(done), 0);
      chk("rst_hold_ram_en", 32'(ram_en), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cmd_ready_after_rst", 32'(cmd_ready), 1);
    chk("busy_after_rst", 32'(busy), 0);
  endtask
  task automatic run_burst(input vec_t v);
    int            issued = 0, got = 0, occ = 0, limit = 4 * int'(v.len) + 40;
    logic          prev_en = 1'b0, hold = 1'b0, hlast = 1'b0, fin = 1'b0, exp_busy;
    logic [DW-1:0] hdata = '0;
    logic [AW-1:0] last_a = '0;
    for (int cyc = 0; cyc < limit && !fin; cyc++) begin
      @(negedge clk);
      cmd_valid = (cyc == 0);
      cmd_base  = v.base;
      cmd_len   = v.len;
      out_ready = ready_for(v.mode, cyc);
      #1;
      if (ram_en) begin
        chk("extra_read", 32'(issued < int'(v.len)), 1);
        chk("ram_addr", 32'(ram_addr), 32'((int'(v.base) + issued) % (1 << AW)));
        last_a = ram_addr;
        issued++;
      end
      chk("ram_we", 32'(ram_we), 0);
      chk("out_valid", 32'(out_valid), 32'(occ > 0));
      chk("inflight_plus_occ_le_2", 32'(int'(prev_en) + occ <= 2), 1);
      if (hold && out_valid) begin
        chk("hold_data", out_data, hdata);
        chk("hold_last", 32'(out_last), 32'(hlast));
      end
      if (out_valid && out_ready) begin
        chk("out_data", out_data, ram[(int'(v.base) + got) % (1 << AW)]);
        chk("out_last", 32'(out_last), 32'(got == int'(v.len) - 1));
        got++;
      end
      if (cyc == 0) chk("done_idle", 32'(done), 0);
      if (done && cyc > 0) begin
        fin = 1'b1;
        if (v.exp_lat != 0) chk("done_latency", 32'(cyc), 32'(v.exp_lat));
        chk("words_out", 32'(got), 32'(v.len));
        chk("reads_issued", 32'(issued), 32'(v.len));
        chk("busy_at_done", 32'(busy), 0);
        chk("cmd_ready_at_done", 32'(cmd_ready), 1);
        if (v.len != 0) chk("last_addr", 32'(last_a), 32'(v.exp_last));
      end else begin
        exp_busy = v.len != 0 && cyc > 0;
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("cmd_ready", 32'(cmd_ready), 32'(!exp_busy));
      end
      occ     = occ + int'(prev_en) - int'(out_valid && out_ready);
      prev_en = ram_en;
      hold    = out_valid && !out_ready;
      hdata   = out_data;
      hlast   = out_last;
      if (v.abort_at != 0 && got == v.abort_at) begin
        do_reset();
        return;
      end
    end
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: no done for base %0h len %0d within %0d cycles", v.base, v.len, limit);
    end
  endtask
  initial begin
    vec_t r;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_ram_we", 32'(ram_we), 0);
    chk("reset_ram_wdata", ram_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cmd_ready_first", 32'(cmd_ready), 1);
    vecs[0]  = '{10'h010, 11'd4,    0, 6,    10'h013, 0};
    vecs[1]  = '{10'h3FE, 11'd4,    0, 6,    10'h001, 0};
    vecs[2]  = '{10'h000, 11'd8,    1, 0,    10'h007, 0};
    vecs[3]  = '{10'h123, 11'd0,    0, 1,    10'h000, 0};
    vecs[4]  = '{10'h200, 11'd1,    0, 3,    10'h200, 0};
    vecs[5]  = '{10'h3FF, 11'd2,    0, 4,    10'h000, 0};
    vecs[6]  = '{10'h050, 11'd8,    2, 0,    10'h057, 0};
    vecs[7]  = '{10'h020, 11'd6,    0, 0,    10'h025, 2};
    vecs[8]  = '{10'h100, 11'd2,    0, 4,    10'h101, 0};
    vecs[9]  = '{10'h3F0, 11'd40,   2, 0,    10'h017, 0};
    vecs[10] = '{10'h004, 11'd1100, 0, 1102, 10'h04F, 0};
    for (int i = 0; i < 11; i++) run_burst(vecs[i]);
    for (int i = 0; i < 15; i++) begin
      r.base     = AW'($urandom_range(0, (1 << AW) - 1));
      r.len      = LW'($urandom_range(0, 24));
      r.mode     = int'($urandom_range(0, 2));
      r.exp_lat  = r.mode != 0 ? 0 : r.len == 0 ? 1 : int'(r.len) + 2;
      r.exp_last = AW'(int'(r.base) + int'(r.len) - 1);
      r.abort_at = 0;
      run_burst(r);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
